// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_t        controller states
//   DIV_WIDTH_DEFAULT  default operand width
//   div_latency()      cycles from accepted start to the done pulse
package div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        SUB,
        DONE
    } div_state_t;

    // Start sampled in cycle k gives done in cycle k + div_latency().
    function automatic int unsigned div_latency(input int unsigned width, input logic div_by_zero);
        return div_by_zero ? 2 : 2 * width + 2;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for seq_restoring_divider.
//   start_i, dividend_i, divisor_i                   requester -> divider
//   busy_o, done_o, quotient_o, remainder_o,
//   div_by_zero_o                                    divider -> requester
// The master modport is for the requester and the slave modport is for the divider.
interface seq_restoring_divider_if import div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
);
    logic             start_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] quotient_o;
    logic [WIDTH-1:0] remainder_o;
    logic             div_by_zero_o;

    modport master (
        output start_i, dividend_i, divisor_i,
        input  busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i,
        output busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
    );
endinterface

// File: rtl/seq_restoring_divider_datapath.sv
// Datapath for the restoring divider. It holds the partial remainder R, the
// quotient/dividend shift register Q, the divisor D, a WIDTH+1-bit subtractor
// with a restore mux, and the result registers. The controller drives it
// through one-hot strobes.
//   capture_i       latch the operands (Q=dividend, D=divisor, R=0) and clear the dbz flag
//   load_i          clear R before the first shift
//   shift_i         {R,Q} <<= 1
//   sub_i           trial subtract; keep the difference or restore, and set Q[0]
//   commit_i        write the result registers (divide-by-zero results when D==0)
//   divisor_zero_o  captured divisor is zero
//   quotient_o, remainder_o, div_by_zero_o   registered results
module seq_div_datapath import div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             capture_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             sub_i,
    input  logic             commit_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             divisor_zero_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   diff;

    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        d_d    = d_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        // The sign bit of the widened difference is the borrow, so it means R < D.
        diff   = {1'b0, r_q} - {1'b0, d_q};

        if (capture_i) begin
            r_d   = '0;
            q_d   = dividend_i;
            d_d   = divisor_i;
            dbz_d = 1'b0;
        end

        if (load_i) begin
            r_d = '0;
        end

        // R never exceeds WIDTH bits here. Before shift i it is at most the
        // top i-1 dividend bits, so it is below 2^(WIDTH-1).
        if (shift_i) begin
            r_d = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
            q_d = {q_q[WIDTH-2:0], 1'b0};
        end

        if (sub_i) begin
            if (!diff[WIDTH]) begin
                r_d    = diff[WIDTH-1:0];
                q_d[0] = 1'b1;
            end else begin
                q_d[0] = 1'b0;
            end
        end

        // The final SUB step commits its own next values, so the results are
        // visible in the DONE cycle. The divide-by-zero commit happens in LOAD,
        // when Q still holds the untouched dividend.
        if (commit_i) begin
            if (d_q == '0) begin
                quot_d = '1;
                rem_d  = q_q;
                dbz_d  = 1'b1;
            end else begin
                quot_d = q_d;
                rem_d  = r_d;
                dbz_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            d_q    <= d_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    assign divisor_zero_o = (d_q == '0);
    assign quotient_o     = quot_q;
    assign remainder_o    = rem_q;
    assign div_by_zero_o  = dbz_q;

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider. It produces one quotient bit per
// SHIFT/SUB pair and then pulses done_o for one cycle. The results stay
// registered until the next accepted start.
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset; it abandons any division in flight
//   bus    slave side of seq_restoring_divider_if:
//          start_i/dividend_i/divisor_i in; busy_o/done_o/quotient_o/
//          remainder_o/div_by_zero_o out
// This module holds the controller FSM and the bit counter. The arithmetic is
// in seq_div_datapath.
module seq_restoring_divider import div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    seq_restoring_divider_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic capture;
    logic load;
    logic shift;
    logic sub;
    logic commit;
    logic divisor_zero;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        sub     = 1'b0;
        commit  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    capture = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (divisor_zero) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end else begin
                    load    = 1'b1;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift   = 1'b1;
                state_d = SUB;
            end
            SUB: begin
                sub = 1'b1;
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.busy_o = (state_q != IDLE);
        bus.done_o = (state_q == DONE);
    end

    seq_div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .capture_i      (capture),
        .load_i         (load),
        .shift_i        (shift),
        .sub_i          (sub),
        .commit_i       (commit),
        .dividend_i     (bus.dividend_i),
        .divisor_i      (bus.divisor_i),
        .divisor_zero_o (divisor_zero),
        .quotient_o     (bus.quotient_o),
        .remainder_o    (bus.remainder_o),
        .div_by_zero_o  (bus.div_by_zero_o)
    );

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider with WIDTH=32.
module tb_seq_restoring_divider;
    import div_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int unsigned  k;
        int unsigned  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_err = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] prod;

    seq_restoring_divider_if #(.WIDTH(W)) if_u ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_u)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int unsigned k);
        exp_t e;
        e.a = a;
        e.b = b;
        e.k = k;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        e.lat = div_latency(W, e.z);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && if_u.done_o) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_val("latency", cyc - mon_e.k, mon_e.lat);
                check_val("quotient", if_u.quotient_o, mon_e.q);
                check_val("remainder", if_u.remainder_o, mon_e.r);
                check_val("dbz", if_u.div_by_zero_o, mon_e.z);
                if (!mon_e.z) begin
                    prod = {32'd0, if_u.quotient_o} * {32'd0, mon_e.b} + {32'd0, if_u.remainder_o};
                    check_val("identity", prod, {32'd0, mon_e.a});
                    check_val("rem_lt_div", if_u.remainder_o < mon_e.b, 1);
                end
            end
        end
    end

    // Called at posedge+1 of an IDLE cycle. It drives start for one cycle and
    // then scrambles the operand inputs.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        if_u.start_i    = 1'b1;
        if_u.dividend_i = a;
        if_u.divisor_i  = b;
        sb.push_back(model(a, b, cyc));
        @(posedge clk); #1;
        if_u.start_i    = 1'b0;
        if_u.dividend_i = $urandom;
        if_u.divisor_i  = $urandom;
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check_val("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b);
        launch(a, b);
        wait_drain();
    endtask

    initial begin
        int unsigned low;
        int unsigned n;
        int unsigned mode;
        logic [W-1:0] a;
        logic [W-1:0] b;

        if_u.start_i    = 1'b0;
        if_u.dividend_i = '0;
        if_u.divisor_i  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", if_u.busy_o, 0);
        check_val("rst_done", if_u.done_o, 0);
        check_val("rst_quot", if_u.quotient_o, 0);
        check_val("rst_rem", if_u.remainder_o, 0);
        check_val("rst_dbz", if_u.div_by_zero_o, 0);
        @(posedge clk); #1;

        // Directed cases
        run(32'd100, 32'd7);
        run(32'hFFFF_FFFF, 32'd1);
        run(32'd3, 32'd10);
        run(32'd5, 32'd0);
        run(32'd9, 32'd3);

        // A start pulse during a run is ignored, and busy stays high throughout.
        launch(32'd100, 32'd7);
        low = 0;
        for (int c = 1; c <= 66; c++) begin
            if (!if_u.busy_o) low++;
            if (c == 10) begin
                if_u.start_i    = 1'b1;
                if_u.dividend_i = 32'd50;
                if_u.divisor_i  = 32'd5;
            end
            if (c == 11) if_u.start_i = 1'b0;
            @(posedge clk); #1;
        end
        check_val("busy_gap_cycles", low, 0);
        wait_drain();
        repeat (5) @(posedge clk);
        #1;

        // A start held through the DONE cycle is accepted in the following IDLE cycle.
        launch(32'd77, 32'd4);
        n = 0;
        while (!if_u.done_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("done_seen", if_u.done_o, 1);
        if_u.start_i    = 1'b1;
        if_u.dividend_i = 32'd20;
        if_u.divisor_i  = 32'd6;
        sb.push_back(model(32'd20, 32'd6, cyc + 1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        if_u.start_i = 1'b0;
        wait_drain();

        // Reset during a run abandons it.
        launch(32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check_val("mid_rst_busy", if_u.busy_o, 0);
        check_val("mid_rst_done", if_u.done_o, 0);
        check_val("mid_rst_quot", if_u.quotient_o, 0);
        check_val("mid_rst_rem", if_u.remainder_o, 0);
        check_val("mid_rst_dbz", if_u.div_by_zero_o, 0);
        repeat (80) @(posedge clk);
        #1;
        run(32'd1000, 32'd33);

        // Random pairs with extreme values mixed in
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0: b = '0;
                1: b = 32'd1;
                2: a = '1;
                3: b = '1;
                4: b = $urandom_range(1, 255);
                5: a = '0;
                6: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            run(a, b);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
